// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: phase-state encodings,
// direction values and the transition classifier.
package quad_pkg;

  localparam logic [1:0] S_00 = 2'b00;
  localparam logic [1:0] S_10 = 2'b10;
  localparam logic [1:0] S_11 = 2'b11;
  localparam logic [1:0] S_01 = 2'b01;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [1:0] {
    TR_NONE,
    TR_FWD,
    TR_REV,
    TR_ILLEGAL
  } trans_e;

  // Successor of s in forward (A leads) order 00->10->11->01->00.
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      S_00:    n = S_10;
      S_10:    n = S_11;
      S_11:    n = S_01;
      default: n = S_00;
    endcase
    return n;
  endfunction

  function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] next);
    trans_e t;
    if (prev == next)                t = TR_NONE;
    else if (next == fwd_next(prev)) t = TR_FWD;
    else if (prev == fwd_next(next)) t = TR_REV;
    else                             t = TR_ILLEGAL;
    return t;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchroniser plus run-length deglitch filter for one asynchronous phase pin.
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic dout_valid
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced;
  logic                   cand_q, cand_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   valid_q, valid_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // cnt tracks how many consecutive synced samples equal cand; the level is
  // accepted on the sample that brings the run up to FILTER_LEN.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din};
    cand_d  = synced;
    cnt_d   = CW'(1);
    dout_d  = dout_q;
    valid_d = valid_q;
    if (synced == cand_q) begin
      cnt_d = (cnt_q == CW'(FILTER_LEN)) ? cnt_q : cnt_q + CW'(1);
    end
    if (cnt_d == CW'(FILTER_LEN)) begin
      dout_d  = cand_d;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: filtered phase tracking, registered step/dir
// pulses, wrapping or saturating position count and sticky illegal-move flag.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter bit          WRAP        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             enable,
  input  logic             clear,
  input  logic             err_clr,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] position,
  output logic             error
);

  logic a_f, b_f, a_valid, b_valid;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .din(quad_a), .dout(a_f), .dout_valid(a_valid)
  );

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .din(quad_b), .dout(b_f), .dout_valid(b_valid)
  );

  logic [1:0]       s_now;
  logic [1:0]       s_q, s_d;
  logic             primed_q, primed_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             error_q, error_d;
  trans_e           trans;

  assign s_now = {a_f, b_f};

  always_comb begin
    s_d      = s_q;
    primed_d = primed_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    pos_d    = pos_q;
    error_d  = err_clr ? 1'b0 : error_q;
    trans    = TR_NONE;

    // Until primed, s_q holds no real reference, so the first state is only loaded.
    if (primed_q) trans = classify(s_q, s_now);
    if (a_valid && b_valid) begin
      s_d      = s_now;
      primed_d = 1'b1;
    end

    if (trans == TR_ILLEGAL) error_d = 1'b1;

    if (enable && (trans == TR_FWD || trans == TR_REV)) begin
      step_d = 1'b1;
      if (trans == TR_FWD) begin
        dir_d = DIR_FWD;
        if (WRAP || pos_q != '1) pos_d = pos_q + WIDTH'(1);
      end else begin
        dir_d = DIR_REV;
        if (WRAP || pos_q != '0) pos_d = pos_q - WIDTH'(1);
      end
    end

    if (clear) pos_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= S_00;
      primed_q <= 1'b0;
      step_q   <= 1'b0;
      dir_q    <= DIR_REV;
      pos_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      s_q      <= s_d;
      primed_q <= primed_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      error_q  <= error_d;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign position = pos_q;
  assign error    = error_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder: wrapping instance plus a saturating
// instance sharing the same pins.
module tb_quadrature_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       err_clr = 1'b0;
  logic       step, dir, error;
  logic [3:0] position;
  logic       step_s, dir_s, error_s;
  logic [3:0] position_s;

  int tests_run    = 0;
  int tests_failed = 0;
  int step_cnt     = 0;
  int sat_cnt      = 0;
  logic last_dir   = 1'b0;
  logic [1:0] cur_s = 2'b00;
  int base;

  always #5 clk = ~clk;

  quadrature_decoder #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(3), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b), .enable(enable),
    .clear(clear), .err_clr(err_clr), .step(step), .dir(dir),
    .position(position), .error(error)
  );

  quadrature_decoder #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(3), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b), .enable(enable),
    .clear(clear), .err_clr(err_clr), .step(step_s), .dir(dir_s),
    .position(position_s), .error(error_s)
  );

  always @(negedge clk) begin
    if (step) begin
      step_cnt++;
      last_dir = dir;
    end
    if (step_s) sat_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive(input logic [1:0] s);
    cur_s = s;
    {quad_a, quad_b} = s;
  endtask

  task automatic step_fwd(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      drive(fwd_of(cur_s));
      repeat (10) tick();
    end
  endtask

  task automatic step_rev(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      drive(rev_of(cur_s));
      repeat (10) tick();
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // 1: reset and priming
    repeat (3) tick();
    check("rst_step", step, 0);
    check("rst_pos", position, 0);
    check("rst_err", error, 0);
    check("rst_dir", dir, 0);
    rst = 1'b0;
    repeat (15) tick();
    check("prime_no_pulse", step_cnt, 0);
    check("prime_pos", position, 0);
    check("prime_err", error, 0);

    // 2: eight forward quarter-steps
    enable = 1'b1;
    step_fwd(8);
    check("fwd8_pulses", step_cnt, 8);
    check("fwd8_dir", last_dir, 1);
    check("fwd8_pos", position, 8);
    check("fwd8_sat_pos", position_s, 8);

    // 3: wrap and saturate
    pulse_clear();
    check("clear_pos", position, 0);
    step_fwd(20);
    check("wrap_fwd_pos", position, 4);
    check("sat_fwd_pos", position_s, 15);
    pulse_clear();
    base = sat_cnt;
    step_rev(5);
    check("wrap_rev_pos", position, 4'b1011);
    check("rev_dir", last_dir, 0);
    check("sat_rev_pos", position_s, 0);
    check("sat_rev_pulses", sat_cnt - base, 5);

    // 4: filter length and latency (cur_s = 01, raising A is a reverse move)
    base = step_cnt;
    quad_a = 1'b1;
    repeat (2) tick();
    quad_a = 1'b0;
    repeat (15) tick();
    check("glitch_no_step", step_cnt - base, 0);
    check("glitch_pos", position, 4'b1011);
    quad_a = 1'b1;
    repeat (3) tick();
    quad_a = 1'b0;
    tick();
    tick();
    check("lat_n4_step", step, 0);
    tick();
    check("lat_n5_step", step, 1);
    check("lat_n5_dir", dir, 0);
    check("lat_n5_pos", position, 4'b1010);
    tick();
    check("lat_n6_step", step, 0);
    repeat (12) tick();
    check("return_fwd_pos", position, 4'b1011);
    check("lat_err", error, 0);

    // 5: illegal transitions and sticky error
    step_fwd(1);
    check("pre_illegal_pos", position, 12);
    base = step_cnt;
    drive(2'b11);
    repeat (10) tick();
    check("illegal_err", error, 1);
    check("illegal_no_step", step_cnt - base, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr", error, 0);
    drive(2'b00);
    repeat (5) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr_vs_illegal", error, 1);
    check("illegal2_no_step", step_cnt - base, 0);
    check("illegal_pos", position, 12);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr2", error, 0);

    // 6: clear vs step, enable low, reset mid-run
    pulse_clear();
    step_fwd(5);
    check("pos5", position, 5);
    drive(fwd_of(cur_s));
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_step", step, 1);
    check("clr_dir", dir, 1);
    check("clr_pos", position, 0);
    check("clr_sat_pos", position_s, 0);
    repeat (10) tick();
    enable = 1'b0;
    base = step_cnt;
    step_fwd(4);
    check("dis_no_step", step_cnt - base, 0);
    check("dis_pos", position, 0);
    enable = 1'b1;
    step_fwd(1);
    check("reen_pos", position, 1);
    drive(fwd_of(cur_s));
    repeat (2) tick();
    #3 rst = 1'b1;
    #1;
    check("midrst_step", step, 0);
    check("midrst_dir", dir, 0);
    check("midrst_pos", position, 0);
    check("midrst_err", error, 0);
    base = step_cnt;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("postrst_no_step", step_cnt - base, 0);
    check("postrst_pos", position, 0);
    check("postrst_err", error, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
